wb_rr_arbiter: RTL

//  Round-robin Wishbone B3 arbiter sharing one slave port (main memory) between NUM_MASTERS

---
 rtl/wb_rr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// Ownership lasts a whole cyc; a per-transfer watchdog aborts stalled slaves.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_t;

    state_t                   state;
    logic [NUM_MASTERS-1:0]   grant_q;
    logic [PW-1:0]            gidx;
    logic [PW-1:0]            ptr;
    logic [WW-1:0]            wd;

    logic [PW-1:0]            pick;
    logic                     found;
    logic [PW-1:0]            ptr_next;
    logic [NUM_MASTERS-1:0]   gmask;
    logic                     cur_cyc;
    logic                     cur_stb;
    logic                     busy;
    logic                     active;
    logic                     resp;
    logic                     fire;

    // First requester at or after ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && wbm_cyc_i[(int'(ptr) + i) % NUM_MASTERS]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + i) % NUM_MASTERS);
            end
        end
    end

    assign ptr_next = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
    assign gmask    = NUM_MASTERS'(1) << gidx;

    assign cur_cyc = wbm_cyc_i[gidx];
    assign cur_stb = wbm_stb_i[gidx];
    assign busy    = (state == BUSY);
    assign active  = busy & cur_cyc & cur_stb;
    assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // A slave response landing on the expiry cycle wins over the watchdog.
    assign fire    = WD_EN & active & ~resp & (wd == WD_MAX);

    assign wbs_adr_o = wbm_adr_i[int'(gidx)*AW +: AW];
    assign wbs_dat_o = wbm_dat_i[int'(gidx)*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[int'(gidx)*SW +: SW];
    assign wbs_cti_o = wbm_cti_i[int'(gidx)*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[int'(gidx)*2 +: 2];
    assign wbs_we_o  = wbm_we_i[gidx];
    assign wbs_cyc_o = busy & cur_cyc;
    assign wbs_stb_o = busy & cur_cyc & cur_stb;

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = (active & wbs_ack_i) ? gmask : '0;
    assign wbm_rty_o = (active & wbs_rty_i) ? gmask : '0;
    assign wbm_err_o = ((active & wbs_err_i) | fire) ? gmask : '0;
    assign grant_o   = grant_q;
    assign timeout_o = fire;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            grant_q <= '0;
            gidx    <= '0;
            ptr     <= '0;
            wd      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (found) begin
                        gidx    <= pick;
                        grant_q <= NUM_MASTERS'(1) << pick;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cur_cyc) begin
                        grant_q <= '0;
                        ptr     <= ptr_next;
                        wd      <= '0;
                        state   <= IDLE;
                    end else if (fire) begin
                        wd    <= '0;
                        state <= ABORT;
                    end else if (!cur_stb || resp) begin
                        wd <= '0;
                    end else if (wd != WD_MAX) begin
                        wd <= wd + WW'(1);
                    end
                end
                ABORT: begin
                    // Owner keeps the bus (silenced) until it gives up the cycle.
                    wd <= '0;
                    if (!cur_cyc) begin
                        grant_q <= '0;
                        ptr     <= ptr_next;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
